mem_access_stage: RTL

Memory-access stage of the five-stage RV32I pipeline. Sits between the EX/MEM register and `MEM_WB_stage`. Performs byte/half/word loads and stores against the data-memory request/ready interface and formats load data. Stalls the upstream pipeline while an access is outstanding and hands `regwrite`/`rd`/`rd_data` to the MEM/WB register.

---
 rtl/riscvx_pkg.sv | 33 +++
 rtl/mem_access_stage_if.sv | 24 ++
 rtl/mem_access_stage_load_formatter.sv | 29 ++
 rtl/mem_access_stage.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/riscvx_pkg.sv
// Shared RV32I memory-stage definitions.
//   - funct3 codes for loads and stores
//   - mem_state_t: memory-stage access FSM states
//   - be_gen(): byte-enable pattern from access width and address low bits
package riscvx_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } mem_state_t;

    // funct3[1:0] encodes width for both loads and stores (bit 2 is only the sign flag).
    function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << addr_lo;
            2'b01:   be = 4'b0011 << addr_lo;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/ready bus.
//   master (pipeline side): drives dmem_req/we/addr/be/wdata, receives dmem_ready/rdata
//   slave  (memory side):   the mirror image
interface mem_access_stage_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_be;
    logic [31:0]       dmem_wdata;
    logic              dmem_ready;
    logic [31:0]       dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage_load_formatter.sv
// load_formatter: picks the addressed byte/half out of a 32-bit memory word and
// sign- or zero-extends it according to the load funct3.
//   rdata   in  32  raw memory word
//   funct3  in  3   load kind (LB/LH/LW/LBU/LHU)
//   addr_lo in  2   byte offset within the word
//   result  out 32  extended load value
module load_formatter
    import riscvx_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] result
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  result = {24'h0, byte_sel};
            F3_LHU:  result = {16'h0, half_sel};
            default: result = rdata;
        endcase
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32I MEM stage. Non-memory ops pass straight through to
// MEM/WB; legal aligned loads/stores run a request/ready access while stalling
// upstream, then present the result for one cycle.
//   clk, reset_n               clock, synchronous active-low reset
//   valid/regwrite/memread/memwrite/funct3/alu_result/rs2_data/rd _MEM : EX/MEM inputs
//   wb_regwrite, wb_rd, wb_rd_data : to MEM/WB register
//   stall_MEM                  freeze upstream pipeline registers
//   mem_fault                  one-cycle pulse on misaligned or illegal access
//   dmem                       data-memory bus (master side)
module mem_access_stage
    import riscvx_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_MEM,
    input  logic        regwrite_MEM,
    input  logic        memread_MEM,
    input  logic        memwrite_MEM,
    input  logic [2:0]  funct3_MEM,
    input  logic [31:0] alu_result_MEM,
    input  logic [31:0] rs2_data_MEM,
    input  logic [4:0]  rd_MEM,
    output logic        wb_regwrite,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_rd_data,
    output logic        stall_MEM,
    output logic        mem_fault,
    mem_access_stage_if.master dmem
);
    mem_state_t        state_q, state_d;
    logic              req_q, we_q, regwrite_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q, rdata_q, load_fmt, wdata_lane;
    logic [2:0]        funct3_q;
    logic [1:0]        addr_lo_q;
    logic [4:0]        rd_q;

    logic [1:0] addr_lo;
    logic       mem_op, f3_ok, aligned, start;
    logic       wb_regwrite_c, stall_c, fault_c;
    logic [4:0] wb_rd_c;
    logic [31:0] wb_rd_data_c;

    assign addr_lo = alu_result_MEM[1:0];

    // Access legality decode.
    always_comb begin
        f3_ok = 1'b0;
        if (memread_MEM && !memwrite_MEM) begin
            f3_ok = funct3_MEM inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        end else if (memwrite_MEM && !memread_MEM) begin
            f3_ok = funct3_MEM inside {F3_SB, F3_SH, F3_SW};
        end
        case (funct3_MEM[1:0])
            2'b01:   aligned = ~addr_lo[0];
            2'b10:   aligned = (addr_lo == 2'b00);
            default: aligned = 1'b1;
        endcase
        mem_op = valid_MEM & (memread_MEM | memwrite_MEM);
        start  = mem_op & f3_ok & aligned;
    end

    // Store data replicated across lanes; byte enables pick the live lane(s).
    always_comb begin
        case (funct3_MEM[1:0])
            2'b00:   wdata_lane = {4{rs2_data_MEM[7:0]}};
            2'b01:   wdata_lane = {2{rs2_data_MEM[15:0]}};
            default: wdata_lane = rs2_data_MEM;
        endcase
    end

    load_formatter u_load_formatter (
        .rdata   (dmem.dmem_rdata),
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .result  (load_fmt)
    );

    always_comb begin
        state_d       = state_q;
        stall_c       = 1'b0;
        fault_c       = 1'b0;
        wb_regwrite_c = 1'b0;
        wb_rd_c       = '0;
        wb_rd_data_c  = '0;
        unique case (state_q)
            StIdle: begin
                if (mem_op) begin
                    if (start) begin
                        stall_c = 1'b1;
                        state_d = StBusy;
                    end else begin
                        fault_c = 1'b1;
                    end
                end else if (valid_MEM) begin
                    wb_regwrite_c = regwrite_MEM & (rd_MEM != 5'd0);
                    wb_rd_c       = rd_MEM;
                    wb_rd_data_c  = alu_result_MEM;
                end
            end
            StBusy: begin
                stall_c = 1'b1;
                if (dmem.dmem_ready) state_d = StDone;
            end
            StDone: begin
                // Upstream advances on this edge, so the op is never re-issued.
                wb_regwrite_c = ~we_q & regwrite_q & (rd_q != 5'd0);
                wb_rd_c       = rd_q;
                wb_rd_data_c  = rdata_q;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            regwrite_q <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            funct3_q   <= '0;
            addr_lo_q  <= '0;
            rd_q       <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && start) begin
                req_q      <= 1'b1;
                we_q       <= memwrite_MEM;
                regwrite_q <= regwrite_MEM;
                addr_q     <= {alu_result_MEM[ADDR_W-1:2], 2'b00};
                be_q       <= be_gen(funct3_MEM, addr_lo);
                wdata_q    <= wdata_lane;
                funct3_q   <= funct3_MEM;
                addr_lo_q  <= addr_lo;
                rd_q       <= rd_MEM;
            end
            if (state_q == StBusy && dmem.dmem_ready) begin
                req_q   <= 1'b0;
                rdata_q <= we_q ? 32'h0 : load_fmt;
            end
        end
    end

    // Every output is held at zero while reset is asserted.
    always_comb begin
        wb_regwrite     = reset_n & wb_regwrite_c;
        wb_rd           = reset_n ? wb_rd_c : 5'd0;
        wb_rd_data      = reset_n ? wb_rd_data_c : 32'h0;
        stall_MEM       = reset_n & stall_c;
        mem_fault       = reset_n & fault_c;
        dmem.dmem_req   = reset_n & req_q;
        dmem.dmem_we    = (reset_n & req_q) & we_q;
        dmem.dmem_addr  = (reset_n & req_q) ? addr_q : '0;
        dmem.dmem_be    = (reset_n & req_q) ? be_q : 4'h0;
        dmem.dmem_wdata = (reset_n & req_q) ? wdata_q : 32'h0;
    end
endmodule
